// File: rtl/mac_lane_array_pkg.sv
// Shared widths and helpers for the multi-lane signed MAC array.
package mac_lane_array_pkg;

  localparam int unsigned DEF_A_WIDTH     = 16;
  localparam int unsigned DEF_B_WIDTH     = 16;
  localparam int unsigned DEF_ACC_WIDTH   = 32;
  localparam int unsigned DEF_OUT_WIDTH   = 16;
  localparam int unsigned DEF_NB_LANES    = 4;
  localparam int unsigned DEF_MAX_ACC_LEN = 576;
  localparam int unsigned SHIFT_W         = 5;

  // Round-half-up arithmetic shift then optional saturation to out_w bits.
  // Evaluated at 64 bits so the rounding add can never overflow the accumulator range.
  function automatic logic signed [63:0] requant(
    input logic signed [63:0]        acc,
    input logic        [SHIFT_W-1:0] shift,
    input logic                      sat,
    input int unsigned               out_w
  );
    logic signed [63:0] rnd;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (shift != '0) ? (64'sd1 <<< (shift - 5'd1)) : 64'sd0;
    r   = (acc + rnd) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    if (sat && (r > hi)) begin
      r = hi;
    end else if (sat && (r < lo)) begin
      r = lo;
    end
    return r;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_lane_array_lane.sv
// One MAC lane: signed product, wrapping accumulator and requantised output register.
module mac_lane
  import mac_lane_array_pkg::*;
#(
  parameter int unsigned A_WIDTH   = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH   = DEF_B_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        acc_en,
  input  logic                        first,
  input  logic                        use_psum,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic signed [ACC_WIDTH-1:0] psum,
  input  logic                        out_load,
  input  logic        [SHIFT_W-1:0]   shift,
  input  logic                        sat,
  output logic        [OUT_WIDTH-1:0] out_data,
  output logic        [ACC_WIDTH-1:0] out_acc
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]       prod_ext;
  logic signed [ACC_WIDTH-1:0]       base;
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic        [OUT_WIDTH-1:0]       out_data_q, out_data_d;
  logic        [ACC_WIDTH-1:0]       out_acc_q, out_acc_d;

  always_comb begin
    prod       = a * b;
    prod_ext   = ACC_WIDTH'(prod);
    base       = first ? (use_psum ? psum : '0) : acc_q;
    acc_d      = acc_en ? (base + prod_ext) : acc_q;
    out_data_d = out_data_q;
    out_acc_d  = out_acc_q;
    if (out_load) begin
      out_data_d = OUT_WIDTH'(requant(64'(acc_q), shift, sat, OUT_WIDTH));
      out_acc_d  = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_q      <= '0;
      out_data_q <= '0;
      out_acc_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_acc_q  <= out_acc_d;
    end
  end

  assign out_data = out_data_q;
  assign out_acc  = out_acc_q;

endmodule

// File: rtl/mac_lane_array.sv
// NB_LANES signed MAC lanes sharing one activation; step counter closes groups,
// results go through a single-entry valid/ready output buffer.
module mac_lane_array
  import mac_lane_array_pkg::*;
#(
  parameter int unsigned A_WIDTH     = DEF_A_WIDTH,
  parameter int unsigned B_WIDTH     = DEF_B_WIDTH,
  parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int unsigned NB_LANES    = DEF_NB_LANES,
  parameter int unsigned MAX_ACC_LEN = DEF_MAX_ACC_LEN
) (
  input  logic                                clk,
  input  logic                                rst_in,
  input  logic [$clog2(MAX_ACC_LEN+1)-1:0]    cfg_acc_len,
  input  logic [SHIFT_W-1:0]                  cfg_shift,
  input  logic                                cfg_saturate,
  input  logic                                cfg_use_psum,
  input  logic [A_WIDTH-1:0]                  a_data,
  input  logic                                a_valid,
  output logic                                a_ready,
  input  logic [NB_LANES*B_WIDTH-1:0]         b_data,
  input  logic                                b_valid,
  output logic                                b_ready,
  input  logic [NB_LANES*ACC_WIDTH-1:0]       psum_in,
  output logic [NB_LANES*OUT_WIDTH-1:0]       out_data,
  output logic [NB_LANES*ACC_WIDTH-1:0]       out_acc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int unsigned LEN_W = $clog2(MAX_ACC_LEN+1);

  logic stall, fire;
  logic step_first, step_last;
  logic [LEN_W-1:0] live_len, cur_len;

  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [SHIFT_W-1:0] grp_shift_q, grp_shift_d;
  logic               grp_sat_q, grp_sat_d;

  logic                          s1_valid_q, s1_valid_d;
  logic                          s1_first_q, s1_first_d;
  logic                          s1_last_q, s1_last_d;
  logic                          s1_use_psum_q, s1_use_psum_d;
  logic [SHIFT_W-1:0]            s1_shift_q, s1_shift_d;
  logic                          s1_sat_q, s1_sat_d;
  logic [A_WIDTH-1:0]            s1_a_q, s1_a_d;
  logic [NB_LANES*B_WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [NB_LANES*ACC_WIDTH-1:0] s1_psum_q, s1_psum_d;

  logic               s2_valid_q, s2_valid_d;
  logic               s2_last_q, s2_last_d;
  logic [SHIFT_W-1:0] s2_shift_q, s2_shift_d;
  logic               s2_sat_q, s2_sat_d;

  logic out_valid_q, out_valid_d;
  logic acc_en, out_load;

  assign stall    = out_valid_q && !out_ready;
  assign a_ready  = !stall && !rst_in;
  assign b_ready  = a_ready;
  assign fire     = a_valid && b_valid && a_ready;
  assign acc_en   = s1_valid_q && !stall;
  assign out_load = s2_valid_q && s2_last_q && !stall;

  // shift/sat travel with each step so a back-to-back group cannot retune
  // the requantisation of the group still draining through the pipeline
  always_comb begin
    live_len   = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
    step_first = (cnt_q == '0);
    cur_len    = step_first ? live_len : len_q;
    step_last  = (cnt_q == (cur_len - LEN_W'(1)));

    cnt_d       = cnt_q;
    len_d       = len_q;
    grp_shift_d = grp_shift_q;
    grp_sat_d   = grp_sat_q;

    s1_valid_d    = s1_valid_q;
    s1_first_d    = s1_first_q;
    s1_last_d     = s1_last_q;
    s1_use_psum_d = s1_use_psum_q;
    s1_shift_d    = s1_shift_q;
    s1_sat_d      = s1_sat_q;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    s1_psum_d     = s1_psum_q;

    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_shift_d = s2_shift_q;
    s2_sat_d   = s2_sat_q;

    out_valid_d = out_valid_q;

    if (!stall) begin
      s1_valid_d  = fire;
      s2_valid_d  = s1_valid_q;
      s2_last_d   = s1_last_q;
      s2_shift_d  = s1_shift_q;
      s2_sat_d    = s1_sat_q;
      out_valid_d = s2_valid_q && s2_last_q;
    end

    if (fire) begin
      cnt_d         = step_last ? '0 : cnt_q + LEN_W'(1);
      s1_first_d    = step_first;
      s1_last_d     = step_last;
      s1_a_d        = a_data;
      s1_b_d        = b_data;
      s1_use_psum_d = step_first && cfg_use_psum;
      s1_shift_d    = step_first ? cfg_shift : grp_shift_q;
      s1_sat_d      = step_first ? cfg_saturate : grp_sat_q;
      if (step_first) begin
        len_d       = live_len;
        grp_shift_d = cfg_shift;
        grp_sat_d   = cfg_saturate;
        s1_psum_d   = psum_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      cnt_q         <= '0;
      len_q         <= '0;
      grp_shift_q   <= '0;
      grp_sat_q     <= '0;
      s1_valid_q    <= '0;
      s1_first_q    <= '0;
      s1_last_q     <= '0;
      s1_use_psum_q <= '0;
      s1_shift_q    <= '0;
      s1_sat_q      <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_psum_q     <= '0;
      s2_valid_q    <= '0;
      s2_last_q     <= '0;
      s2_shift_q    <= '0;
      s2_sat_q      <= '0;
      out_valid_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      grp_shift_q   <= grp_shift_d;
      grp_sat_q     <= grp_sat_d;
      s1_valid_q    <= s1_valid_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s1_use_psum_q <= s1_use_psum_d;
      s1_shift_q    <= s1_shift_d;
      s1_sat_q      <= s1_sat_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_psum_q     <= s1_psum_d;
      s2_valid_q    <= s2_valid_d;
      s2_last_q     <= s2_last_d;
      s2_shift_q    <= s2_shift_d;
      s2_sat_q      <= s2_sat_d;
      out_valid_q   <= out_valid_d;
    end
  end

  for (genvar i = 0; i < int'(NB_LANES); i++) begin : g_lane
    mac_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_in  (rst_in),
      .acc_en  (acc_en),
      .first   (s1_first_q),
      .use_psum(s1_use_psum_q),
      .a       (s1_a_q),
      .b       (s1_b_q[lane_lsb(i, B_WIDTH) +: B_WIDTH]),
      .psum    (s1_psum_q[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH]),
      .out_load(out_load),
      .shift   (s2_shift_q),
      .sat     (s2_sat_q),
      .out_data(out_data[lane_lsb(i, OUT_WIDTH) +: OUT_WIDTH]),
      .out_acc (out_acc[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH])
    );
  end

  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != '0) || s1_valid_q || s2_valid_q || out_valid_q;

endmodule

// File: doc/mac_lane_array.md
Name: mac_lane_array

Overview:
- Parametrised successor to the single-MAC datapath: NB_LANES signed MAC lanes share one broadcast activation; each lane takes its own weight.
- An internal step counter closes each accumulation group, replacing per-step controller accumulate strobes.
- Optional external partial-sum preload.
- Output path applies rounding shift and saturation, then a single-entry output buffer with valid/ready back-pressure.
- Sits between the controller/IO registers and the external memory / output port.

Parameters:
- A_WIDTH, 16, activation width, signed.
- B_WIDTH, 16, weight width per lane, signed.
- ACC_WIDTH, 32, accumulator width per lane.
- OUT_WIDTH, 16, requantised output width per lane.
- NB_LANES, 4, number of parallel MAC lanes.
- MAX_ACC_LEN, 576, maximum steps per accumulation group (3*3*64).

Ports:
- clk  in  1  clock
- rst_in  in  1  synchronous reset, active-high
- cfg_acc_len  in  $clog2(MAX_ACC_LEN+1)  steps per group; 0 treated as 1
- cfg_shift  in  5  arithmetic right shift applied to the result
- cfg_saturate  in  1  1 = saturate to OUT_WIDTH, 0 = truncate
- cfg_use_psum  in  1  1 = preload accumulator from psum_in at group start
- a_data  in  A_WIDTH  broadcast activation
- a_valid  in  1  activation valid
- a_ready  out  1  activation accepted
- b_data  in  NB_LANES*B_WIDTH  per-lane weights; lane i at bits [i*B_WIDTH +: B_WIDTH]
- b_valid  in  1  weights valid
- b_ready  out  1  weights accepted
- psum_in  in  NB_LANES*ACC_WIDTH  partial sums; sampled with the first step of a group
- out_data  out  NB_LANES*OUT_WIDTH  requantised results
- out_acc  out  NB_LANES*ACC_WIDTH  raw accumulators, for external memory write-back
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- busy  out  1  group in progress or pipeline non-empty

Behaviour:
- Reset (rst_in=1 at an edge): out_valid=0, out_data=0, out_acc=0, busy=0, step counter=0, all stage-valid bits cleared. A partially accumulated group is discarded. While rst_in=1, a_ready=b_ready=0.
- stall = out_valid && !out_ready. While stall=1, every pipeline register holds its value.
- a_ready = b_ready = !stall && !rst_in. Ready never depends on valid.
- A step fires only when a_valid && b_valid && a_ready. A lone a_valid or lone b_valid consumes nothing.
- Stage S1: edge ending fire cycle N registers a, b, first = (cnt==0), last = (cnt==len-1).
- On first: cfg_* and psum_in are latched; cfg changes mid-group are ignored.
- Stage S2: edge ending cycle N+1 updates each lane accumulator:
  - first: acc = (use_psum ? psum : 0) + a*b_i
  - otherwise: acc = acc + a*b_i
- Product is signed, A_WIDTH+B_WIDTH bits, sign-extended. Accumulation wraps modulo 2^ACC_WIDTH with no overflow flag.
- Step counter increments per fire and wraps to 0 after len-1. Back-to-back groups need no idle cycle.
- Output: for a last step, the output register loads at the edge ending N+2, so out_valid=1 from cycle N+3. Latency fire-to-valid is 3 cycles when not stalled.
- Requantisation per lane:
  - r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, round half up, computed in ACC_WIDTH+1 bits.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] if cfg_saturate, else keep the low OUT_WIDTH bits.
- out_acc carries the unshifted acc.
- out_valid && out_ready in the same cycle that a new result arrives: the buffer reloads with no bubble.
- out_data and out_acc are stable while out_valid && !out_ready.
- busy = (cnt != 0) || S1 valid || S2 valid || out_valid.

Decomposition:
- Package mac_lane_array_pkg holds:
  - default width constants
  - function requant(acc, shift, sat)
  - lane slicing helpers.
- Sub-module mac_lane (one lane: product, accumulator register, requant) is instantiated NB_LANES times by generate.
- Step counter, handshake and stall logic stay in the top.

Test Plan:
- len=1, use_psum=0, shift=0, a=3, b={2,-4,5,7} -> out_data={6,-12,15,21}, out_valid exactly 3 cycles after the fire.
- len=3, a=2,3,4 with all b=1; then the same with use_psum=1, psum=100 -> {9,9,9,9}, then {109,109,109,109}; second group starts the cycle after the first's last fire.
- len=1, a=32767, b=32767 on all lanes; sat=1 -> 32767; sat=0 -> 1 (0x3FFF0001 low bits); shift=4 with products 24 / -24 -> 2 / -1.
- out_ready=0 across three len=1 groups -> first result held stable, a_ready=0 while stalled, no result lost; raising out_ready yields results in order, one per cycle.
- Random a_valid/b_valid gaps with len=5 -> results match a golden model; no step is consumed when only one of the two valids is high.
- len=4: 2 fires, then rst_in for 1 cycle, then a fresh 4-step group -> no output from the aborted group; the new result excludes pre-reset products.
